// File: rtl/PARAMS_pkg.sv
// Shared datapath widths and the register-file address/word types.
package PARAMS_pkg;
    localparam int WD_SIZE        = 32;
    localparam int INSTR_REG_BITS = 5;

    typedef logic [INSTR_REG_BITS-1:0] reg_addr_t;
    typedef logic [WD_SIZE-1:0]        word_t;
endpackage

// File: rtl/regfile_wr_arbiter.sv
// Resolves the write ports into per-register write/clear strobes and per-read-port
// bypass/clear hits. When several ports hit one address, the highest port index wins.
module regfile_wr_arbiter
    import PARAMS_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1
) (
    input  logic      [NUM_WR-1:0]  wr_en_i,
    input  reg_addr_t [NUM_WR-1:0]  wr_addr_i,
    input  word_t     [NUM_WR-1:0]  wr_data_i,
    input  logic      [NUM_WR-1:0]  wr_clr_i,
    input  reg_addr_t [NUM_RD-1:0]  rd_addr_i,
    output logic      [REG_NUM-1:0] reg_we_o,
    output word_t     [REG_NUM-1:0] reg_wd_o,
    output logic      [REG_NUM-1:0] reg_clr_o,
    output logic      [NUM_RD-1:0]  byp_hit_o,
    output word_t     [NUM_RD-1:0]  byp_data_o,
    output logic      [NUM_RD-1:0]  clr_hit_o
);
    always_comb begin
        for (int r = 0; r < REG_NUM; r++) begin
            reg_we_o[r]  = 1'b0;
            reg_wd_o[r]  = '0;
            reg_clr_o[r] = 1'b0;
            // Ascending scan: a later (higher) port overrides an earlier one.
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && wr_addr_i[j] == reg_addr_t'(r)) begin
                    reg_we_o[r] = (r != 0);
                    reg_wd_o[r] = wr_data_i[j];
                    if (wr_clr_i[j]) reg_clr_o[r] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            byp_hit_o[i]  = 1'b0;
            byp_data_o[i] = '0;
            clr_hit_o[i]  = 1'b0;
            for (int j = 0; j < NUM_WR; j++) begin
                if (wr_en_i[j] && wr_addr_i[j] == rd_addr_i[i] && rd_addr_i[i] != '0) begin
                    byp_hit_o[i]  = 1'b1;
                    byp_data_o[i] = wr_data_i[j];
                    if (wr_clr_i[j]) clr_hit_o[i] = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_mp_scoreboard.sv
// Multi-port integer register file with optional write->read bypass and a
// per-register pending scoreboard for RAW stalls. x0 reads zero, never pending.
module regfile_mp_scoreboard
    import PARAMS_pkg::*;
#(
    parameter int REG_NUM = 32,
    parameter int NUM_RD  = 2,
    parameter int NUM_WR  = 1,
    parameter int BYPASS  = 1,
    localparam int CNT_W  = $clog2(REG_NUM + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  reg_addr_t [NUM_RD-1:0]  rd_addr,
    output word_t     [NUM_RD-1:0]  rd_data,
    output logic      [NUM_RD-1:0]  rd_busy,
    input  logic      [NUM_WR-1:0]  wr_en,
    input  reg_addr_t [NUM_WR-1:0]  wr_addr,
    input  word_t     [NUM_WR-1:0]  wr_data,
    input  logic      [NUM_WR-1:0]  wr_clr,
    input  logic                    issue_en,
    input  reg_addr_t               issue_rd,
    output logic      [CNT_W-1:0]   pending_cnt
);
    word_t [REG_NUM-1:0] regs_q;
    logic  [REG_NUM-1:0] pending_q, pending_d;
    logic  [CNT_W-1:0]   cnt_q, cnt_d;

    logic  [REG_NUM-1:0] reg_we, reg_clr;
    word_t [REG_NUM-1:0] reg_wd;
    logic  [NUM_RD-1:0]  byp_hit, clr_hit;
    word_t [NUM_RD-1:0]  byp_data;

    regfile_wr_arbiter #(
        .REG_NUM (REG_NUM),
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR)
    ) u_arb (
        .wr_en_i    (wr_en),
        .wr_addr_i  (wr_addr),
        .wr_data_i  (wr_data),
        .wr_clr_i   (wr_clr),
        .rd_addr_i  (rd_addr),
        .reg_we_o   (reg_we),
        .reg_wd_o   (reg_wd),
        .reg_clr_o  (reg_clr),
        .byp_hit_o  (byp_hit),
        .byp_data_o (byp_data),
        .clr_hit_o  (clr_hit)
    );

    always_comb begin
        for (int i = 0; i < NUM_RD; i++) begin
            rd_data[i] = regs_q[rd_addr[i]];
            if (rd_addr[i] == '0)                  rd_data[i] = '0;
            else if (BYPASS != 0 && byp_hit[i])    rd_data[i] = byp_data[i];
            // Issue is deliberately absent here: busy follows registered state only.
            rd_busy[i] = pending_q[rd_addr[i]] & ~((BYPASS != 0) & clr_hit[i]);
        end
    end

    // A new allocation outranks a retiring producer of the same register.
    always_comb begin
        cnt_d = '0;
        for (int r = 0; r < REG_NUM; r++) begin
            if (issue_en && issue_rd == reg_addr_t'(r)) pending_d[r] = 1'b1;
            else if (reg_clr[r])                        pending_d[r] = 1'b0;
            else                                        pending_d[r] = pending_q[r];
        end
        pending_d[0] = 1'b0;
        for (int r = 0; r < REG_NUM; r++) cnt_d = cnt_d + CNT_W'(pending_d[r]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q    <= '0;
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            for (int r = 0; r < REG_NUM; r++)
                if (reg_we[r]) regs_q[r] <= reg_wd[r];
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;
endmodule
